blvds_link_ctrl: RTL and testbench

BLVDS_LINK_CTRL -- requirements
Module: blvds_link_ctrl

---
 rtl/blvds_link_pkg.sv | 29 ++
 rtl/blvds_link_rx.sv | 71 +++++++
 rtl/blvds_link_ctrl.sv | 166 ++++++++++++++++
 tb/tb_blvds_link_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blvds_link_pkg.sv
// rtl/blvds_link_pkg.sv - shared state encoding, line constants and counter sizing for the BLVDS link
//
// Contents:
//   link_state_t  : link controller states (transmit and receive share one FSM)
//   START_BIT     : line level of a frame start bit
//   STOP_BIT      : line level of a frame stop bit; also the idle/terminated level
//   bit_cnt_width : width of a down-counter that must hold max_count

package blvds_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_TURN,
        ST_RX_DATA,
        ST_RX_STOP
    } link_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int bit_cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/blvds_link_rx.sv
// rtl/blvds_link_rx.sv - BLVDS link deserializer with stop-bit and optional parity check
//
// Optional feature: BLVDS_LINK_PARITY_EN adds an even-parity bit after the data bits.
//
// Ports:
//   clk       : clock, rising edge
//   resetn    : synchronous active-low reset
//   shift_en  : sample line into the shift register this edge (one per data/parity bit)
//   check_en  : sample line as the stop bit this edge and judge the frame
//   line      : received line level
//   rx_tdata  : last good received word
//   rx_tvalid : one-cycle pulse, rx_tdata newly updated
//   rx_err    : one-cycle pulse, stop (or parity) error

module blvds_link_rx
    import blvds_link_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             shift_en,
    input  logic             check_en,
    input  logic             line,
    output logic [WIDTH-1:0] rx_tdata,
    output logic             rx_tvalid,
    output logic             rx_err
);

`ifdef BLVDS_LINK_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    logic [NBITS-1:0] shreg;
    logic             frame_ok;

    // Bits arrive LSB first and enter at the top, so after NBITS shifts the
    // first received bit sits at index 0 and the parity bit (if any) on top.
`ifdef BLVDS_LINK_PARITY_EN
    // Even parity: XOR over data plus parity bit must be zero.
    assign frame_ok = (line == STOP_BIT) && !(^shreg);
`else
    assign frame_ok = (line == STOP_BIT);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shreg     <= '0;
            rx_tdata  <= '0;
            rx_tvalid <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            rx_tvalid <= 1'b0;
            rx_err    <= 1'b0;
            if (shift_en) begin
                shreg <= {line, shreg[NBITS-1:1]};
            end
            if (check_en) begin
                if (frame_ok) begin
                    rx_tdata  <= shreg[WIDTH-1:0];
                    rx_tvalid <= 1'b1;
                end else begin
                    rx_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/blvds_link_ctrl.sv
// rtl/blvds_link_ctrl.sv - half-duplex BLVDS link controller: transmit FSM, bus arbitration, T/I drive
//
// Optional feature: BLVDS_LINK_PARITY_EN adds an even-parity bit after the data bits
// (frame WIDTH+3 bits instead of WIDTH+2).
//
// Parameters:
//   WIDTH : payload bits per frame (4..16)
//   TURN  : guard cycles with the bus released after a transmit (1..15)
// Ports:
//   CLK      : sole clock, rising edge
//   RST_N    : synchronous active-low reset
//   TX_DATA  : word to send, captured at transfer
//   TX_VALID : TX_DATA valid
//   TX_READY : word accepted this cycle (idle and line idle)
//   RX_DATA  : last good received word
//   RX_VALID : one-cycle pulse, RX_DATA newly updated
//   RX_ERR   : one-cycle pulse, framing/parity error
//   I        : serial data to the buffer I input (1 whenever released)
//   T        : buffer tristate control, 1 = released, 0 = driving
//   O        : line state from the buffer O output

module blvds_link_ctrl
    import blvds_link_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TURN  = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic             RX_ERR,
    output logic             I,
    output logic             T,
    input  logic             O
);

`ifdef BLVDS_LINK_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    localparam int CNT_MAX = (NBITS > TURN) ? NBITS : TURN;
    localparam int CW      = bit_cnt_width(CNT_MAX);

    localparam logic [CW-1:0] LAST_BIT  = CW'(NBITS - 1);
    localparam logic [CW-1:0] LAST_TURN = CW'(TURN - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    link_state_t      state;
    logic [CW-1:0]    cnt;
    logic [NBITS-1:0] tx_shreg;
    logic [NBITS-1:0] tx_frame;
    logic             ready_en;
    logic             rx_shift;
    logic             rx_check;

`ifdef BLVDS_LINK_PARITY_EN
    assign tx_frame = {^TX_DATA, TX_DATA};
`else
    assign tx_frame = TX_DATA;
`endif

    // ready_en holds TX_READY low for the first cycle after reset release so
    // that acceptance starts only once a non-reset edge has been seen.
    assign TX_READY = ready_en && (state == ST_IDLE) && (O == STOP_BIT);

    assign rx_shift = (state == ST_RX_DATA);
    assign rx_check = (state == ST_RX_STOP);

    // T and I are registered with the state so the buffer sees glitch-free
    // controls; O is only looked at in IDLE and in the receive states, which
    // keeps our own transmit echo and the turnaround window out of the receiver.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tx_shreg <= '0;
            ready_en <= 1'b0;
            T        <= 1'b1;
            I        <= 1'b1;
        end else begin
            ready_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    // A start bit on the line wins over a pending transmit.
                    if (O == START_BIT) begin
                        state <= ST_RX_DATA;
                        cnt   <= LAST_BIT;
                    end else if (TX_VALID && TX_READY) begin
                        state    <= ST_PRE;
                        tx_shreg <= tx_frame;
                        T        <= 1'b0;
                        I        <= STOP_BIT;
                    end
                end
                ST_PRE: begin
                    state <= ST_START;
                    I     <= START_BIT;
                end
                ST_START: begin
                    state    <= ST_DATA;
                    I        <= tx_shreg[0];
                    tx_shreg <= {1'b0, tx_shreg[NBITS-1:1]};
                    cnt      <= LAST_BIT;
                end
                ST_DATA: begin
                    if (cnt == '0) begin
                        state <= ST_STOP;
                        I     <= STOP_BIT;
                    end else begin
                        I        <= tx_shreg[0];
                        tx_shreg <= {1'b0, tx_shreg[NBITS-1:1]};
                        cnt      <= cnt - CNT_ONE;
                    end
                end
                ST_STOP: begin
                    state <= ST_TURN;
                    T     <= 1'b1;
                    I     <= 1'b1;
                    cnt   <= LAST_TURN;
                end
                ST_TURN: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_RX_DATA: begin
                    if (cnt == '0) begin
                        state <= ST_RX_STOP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_RX_STOP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    T     <= 1'b1;
                    I     <= 1'b1;
                end
            endcase
        end
    end

    blvds_link_rx #(
        .WIDTH(WIDTH)
    ) u_rx (
        .clk      (CLK),
        .resetn   (RST_N),
        .shift_en (rx_shift),
        .check_en (rx_check),
        .line     (O),
        .rx_tdata (RX_DATA),
        .rx_tvalid(RX_VALID),
        .rx_err   (RX_ERR)
    );

endmodule

// File: tb/tb_blvds_link_ctrl.sv
// tb/tb_blvds_link_ctrl.sv - randomized self-checking bench for blvds_link_ctrl against a frame-level model

module tb_blvds_link_ctrl;

    localparam int WIDTH = 8;
    localparam int TURN  = 2;
`ifdef BLVDS_LINK_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [WIDTH-1:0] TX_DATA = '0;
    logic             TX_VALID = 1'b0;
    logic             TX_READY;
    logic [WIDTH-1:0] RX_DATA;
    logic             RX_VALID;
    logic             RX_ERR;
    logic             I;
    logic             T;
    logic             O = 1'b1;

    blvds_link_ctrl #(
        .WIDTH(WIDTH),
        .TURN (TURN)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .TX_DATA (TX_DATA),
        .TX_VALID(TX_VALID),
        .TX_READY(TX_READY),
        .RX_DATA (RX_DATA),
        .RX_VALID(RX_VALID),
        .RX_ERR  (RX_ERR),
        .I       (I),
        .T       (T),
        .O       (O)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: last good word and the pulse expected after the latest frame.
    logic [WIDTH-1:0] model_rx = '0;
    logic             exp_v = 1'b0;
    logic             exp_e = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic check_pending();
        check("rx_valid", RX_VALID, exp_v);
        check("rx_err", RX_ERR, exp_e);
        check("rx_data", RX_DATA, model_rx);
        exp_v = 1'b0;
        exp_e = 1'b0;
    endtask

    task automatic settle();
        O = 1'b1;
        #1;
        check_pending();
    endtask

    // Checks one transmit frame starting in the cycle right after the transfer edge.
    task automatic tx_body(input logic [WIDTH-1:0] data);
        logic [WIDTH+PBITS+2:0] bits;
        int nf;
        nf = WIDTH + PBITS + 3;
        bits = '1;
        bits[0] = 1'b1;
        bits[1] = 1'b0;
        for (int j = 0; j < WIDTH; j++) bits[2+j] = data[j];
        if (PBITS == 1) bits[2+WIDTH] = ^data;
        bits[nf-1] = 1'b1;
        for (int k = 0; k < nf; k++) begin
            O = 1'($urandom_range(0, 1));
            TX_DATA = WIDTH'($urandom);
            #1;
            check("tx_t_drive", T, 0);
            check("tx_i_bit", I, bits[k]);
            check("tx_no_rxv", RX_VALID, 0);
            check("tx_no_rxe", RX_ERR, 0);
            tick();
        end
        for (int k = 0; k < TURN; k++) begin
            O = 1'b1;
            #1;
            check("turn_t", T, 1);
            check("turn_i", I, 1);
            check("turn_ready", TX_READY, 0);
            tick();
        end
        #1;
        check("ready_after_turn", TX_READY, 1);
    endtask

    task automatic send(input logic [WIDTH-1:0] data);
        int waited;
        waited = 0;
        O = 1'b1;
        TX_DATA = data;
        TX_VALID = 1'b1;
        #1;
        check_pending();
        while (!TX_READY && waited < 40) begin
            tick();
            #1;
            waited++;
        end
        check("tx_ready_wait", (waited < 40), 1);
        tick();
        TX_VALID = 1'b0;
        tx_body(data);
    endtask

    // Drives one frame onto O starting in an IDLE cycle; leaves the expected
    // pulse pending for the cycle after the stop bit.
    task automatic recv(input logic [WIDTH-1:0] data, input logic stop, input logic par_good);
        logic [WIDTH+PBITS+1:0] bits;
        int nf;
        logic good;
        nf = WIDTH + PBITS + 2;
        bits = '1;
        bits[0] = 1'b0;
        for (int j = 0; j < WIDTH; j++) bits[1+j] = data[j];
        if (PBITS == 1) bits[1+WIDTH] = (^data) ^ ~par_good;
        bits[nf-1] = stop;
        for (int k = 0; k < nf; k++) begin
            O = bits[k];
            #1;
            if (k == 0) begin
                check_pending();
            end else begin
                check("rx_mid_valid", RX_VALID, 0);
                check("rx_mid_err", RX_ERR, 0);
            end
            check("rx_no_ready", TX_READY, 0);
            check("rx_t_released", T, 1);
            check("rx_i_idle", I, 1);
            tick();
        end
        good = stop && ((PBITS == 0) || par_good);
        exp_v = good;
        exp_e = ~good;
        if (good) model_rx = data;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        int op;

        // Reset behaviour
        tick();
        tick();
        #1;
        check("rst_t", T, 1);
        check("rst_i", I, 1);
        check("rst_ready", TX_READY, 0);
        check("rst_rxv", RX_VALID, 0);
        check("rst_rxe", RX_ERR, 0);
        check("rst_rxd", RX_DATA, 0);
        RST_N = 1'b1;
        #1;
        check("ready_not_yet", TX_READY, 0);
        tick();
        #1;
        check("ready_first", TX_READY, 1);

        // Directed frames
        send(8'hA5);
        recv(8'h3C, 1'b1, 1'b1);
        settle();
        tick();
        recv(8'h3C, 1'b0, 1'b1);
        settle();
        tick();
        if (PBITS == 1) begin
            recv(8'h07, 1'b1, 1'b0);
            recv(8'h07, 1'b1, 1'b1);
            settle();
            tick();
        end

        // Start bit and TX_VALID in the same cycle: receive first, then transmit
        TX_DATA = 8'h5A;
        TX_VALID = 1'b1;
        recv(WIDTH'($urandom), 1'b1, 1'b1);
        settle();
        check("coll_ready", TX_READY, 1);
        tick();
        TX_VALID = 1'b0;
        tx_body(8'h5A);

        // Reset during DATA bit 4
        TX_DATA = WIDTH'($urandom);
        TX_VALID = 1'b1;
        #1;
        check("mid_ready", TX_READY, 1);
        tick();
        TX_VALID = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        #1;
        check("mid_driving", T, 0);
        RST_N = 1'b0;
        tick();
        #1;
        model_rx = '0;
        check("mid_rst_t", T, 1);
        check("mid_rst_i", I, 1);
        check("mid_rst_ready", TX_READY, 0);
        check("mid_rst_rxd", RX_DATA, 0);
        RST_N = 1'b1;
        #1;
        check("mid_ready_hold", TX_READY, 0);
        tick();
        #1;
        check("mid_ready_back", TX_READY, 1);
        check("mid_no_resume", T, 1);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            d = WIDTH'($urandom);
            case (op)
                0: send(d);
                1: recv(d, 1'b1, 1'b1);
                2: recv(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default: begin
                    recv(d, 1'b1, 1'b1);
                    recv(WIDTH'($urandom), 1'b1, 1'b1);
                end
            endcase
            if ($urandom_range(0, 1) == 1) begin
                settle();
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
            end
        end
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
